// File: rtl/uart_rx_pkg.sv
// Shared types for the UART receive capture block: FSM state encoding,
// parity mode encodings and the parity reference helper.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Line value the parity bit must carry for the given payload.
  function automatic logic parity_bit(input logic [8:0] payload, input int mode);
    return (mode == PARITY_ODD) ? ~(^payload) : ^payload;
  endfunction

endpackage

// File: rtl/uart_rx_capture_if.sv
// Read side of the receive FIFO: head data, valid/ready pop handshake and occupancy.
interface uart_rx_capture_if #(
  parameter int DATA_BITS = 8,
  parameter int CNT_W     = 4
);
  logic [DATA_BITS-1:0] rdata;
  logic                 rvalid;
  logic                 rready;
  logic [CNT_W-1:0]     count;

  modport master (output rdata, rvalid, count, input rready);
  modport slave  (input rdata, rvalid, count, output rready);
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive FIFO: power-of-two depth, pointers wrap naturally, full+push+pop accepted together.
module uart_rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push_i,
  input  logic [DATA_BITS-1:0] wdata_i,
  output logic                 drop_o,
  uart_rx_capture_if.master    rd
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q;
  logic                 rvalid, full, pop, wr_en;

  assign rvalid = (count_q != '0);
  assign full   = (count_q == CW'(FIFO_DEPTH));
  assign pop    = rvalid && rd.rready;
  assign wr_en  = push_i && (!full || pop);
  assign drop_o = push_i && full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({wr_en, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage carries no reset; the head is gated by rvalid, so stale entries never reach the port.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rd.rvalid = rvalid;
  assign rd.rdata  = rvalid ? mem_q[rd_ptr_q] : '0;
  assign rd.count  = count_q;

endmodule

// File: rtl/uart_rx_capture.sv
// UART receiver: synchronised line, mid-bit sampling FSM with parity/stop checks,
// sticky error flags and a small receive FIFO for the consumer.
module uart_rx_capture
  import uart_rx_pkg::*;
#(
  parameter int CLK_DIV     = 32,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx_i,
  input  logic                          rx_en_i,
  output logic [DATA_BITS-1:0]          rdata_o,
  output logic                          rvalid_o,
  input  logic                          rready_i,
  output logic [$clog2(FIFO_DEPTH):0]   count_o,
  output logic                          frame_err_o,
  output logic                          parity_err_o,
  output logic                          overrun_o,
  input  logic                          clr_err_i
);
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DIV_W-1:0] HALF_BIT  = DIV_W'(CLK_DIV / 2 - 1);
  localparam logic [DIV_W-1:0] FULL_BIT  = DIV_W'(CLK_DIV - 1);
  localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);

  logic                 sync1_q, sync2_q, rx_prev_q, rx_s;
  rx_state_e            state_q;
  logic [DIV_W-1:0]     tick_q;
  logic                 bit_tick;
  logic [3:0]           bit_idx_q;
  logic                 stop_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 discard_q, push_q;
  logic                 frame_err_q, parity_err_q, overrun_q;
  logic                 fifo_drop;

  // NOTE: the synchroniser resets to the idle line level so reset release never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= rx_i;
      sync2_q   <= sync1_q;
      rx_prev_q <= sync2_q;
    end
  end

  assign rx_s     = sync2_q;
  assign bit_tick = (tick_q == '0);

  // Error sets are written after the clear so a same-cycle error keeps its flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      tick_q       <= '0;
      bit_idx_q    <= '0;
      stop_idx_q   <= 1'b0;
      shift_q      <= '0;
      discard_q    <= 1'b0;
      push_q       <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      push_q <= 1'b0;
      if (clr_err_i) begin
        frame_err_q  <= 1'b0;
        parity_err_q <= 1'b0;
        overrun_q    <= 1'b0;
      end
      if (fifo_drop) overrun_q <= 1'b1;
      if (state_q != IDLE && state_q != BREAK)
        tick_q <= bit_tick ? FULL_BIT : tick_q - DIV_W'(1);

      unique case (state_q)
        IDLE: begin
          if (rx_en_i && rx_prev_q && !rx_s) begin
            state_q <= START;
            tick_q  <= HALF_BIT;
          end
        end
        START: begin
          if (bit_tick) begin
            if (rx_s) begin
              state_q <= IDLE;
            end else begin
              state_q   <= DATA;
              bit_idx_q <= '0;
              discard_q <= 1'b0;
            end
          end
        end
        DATA: begin
          if (bit_tick) begin
            shift_q   <= {rx_s, shift_q[DATA_BITS-1:1]};
            bit_idx_q <= bit_idx_q + 4'd1;
            if (bit_idx_q == LAST_DATA) begin
              state_q    <= (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
              stop_idx_q <= 1'b0;
            end
          end
        end
        PARITY: begin
          if (bit_tick) begin
            if (rx_s != parity_bit(9'(shift_q), PARITY_MODE)) begin
              parity_err_q <= 1'b1;
              discard_q    <= 1'b1;
            end
            state_q <= STOP;
          end
        end
        STOP: begin
          if (bit_tick) begin
            if (!rx_s) begin
              frame_err_q <= 1'b1;
              state_q     <= BREAK;
            end else if (stop_idx_q == 1'(STOP_BITS - 1)) begin
              push_q  <= !discard_q;
              state_q <= IDLE;
            end else begin
              stop_idx_q <= 1'b1;
            end
          end
        end
        BREAK: begin
          if (rx_s) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  uart_rx_capture_if #(.DATA_BITS(DATA_BITS), .CNT_W(CNT_W)) rd_if ();

  uart_rx_fifo #(
    .DATA_BITS  (DATA_BITS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_q),
    .wdata_i (shift_q),
    .drop_o  (fifo_drop),
    .rd      (rd_if.master)
  );

  assign rd_if.rready = rready_i;
  assign rdata_o      = rd_if.rdata;
  assign rvalid_o     = rd_if.rvalid;
  assign count_o      = rd_if.count;
  assign frame_err_o  = frame_err_q;
  assign parity_err_o = parity_err_q;
  assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_uart_rx_capture.sv
// Scoreboard bench: dut_a uses default parameters, dut_b uses even parity and a 4-entry FIFO.
module tb_uart_rx_capture;
  import uart_rx_pkg::*;

  localparam int C_A = 32;
  localparam int C_B = 16;
  // Negedge index (from the start-bit negedge) at which dut_a shows rvalid.
  localparam int RISE_A = 3 + (C_A / 2 - 1) + C_A * 9 + 2;
  // Negedge index at which dut_b is inside its push cycle.
  localparam int PUSH_B = 3 + (C_B / 2 - 1) + C_B * 10 + 1;

  typedef struct {
    logic [7:0] data;
    int         rise;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_a = 1'b1, rx_b = 1'b1;
  logic en_a = 1'b1, en_b = 1'b1;
  logic clr_a = 1'b0, clr_b = 1'b0;
  logic fe_a, pe_a, ov_a, fe_b, pe_b, ov_b;

  exp_t       q_a[$];
  logic [7:0] q_b[$];
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int break_seen = 0;

  uart_rx_capture_if #(.DATA_BITS(8), .CNT_W(4)) rd_a ();
  uart_rx_capture_if #(.DATA_BITS(8), .CNT_W(3)) rd_b ();

  always #5 clk = ~clk;

  uart_rx_capture dut_a (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_i         (rx_a),
    .rx_en_i      (en_a),
    .rdata_o      (rd_a.rdata),
    .rvalid_o     (rd_a.rvalid),
    .rready_i     (rd_a.rready),
    .count_o      (rd_a.count),
    .frame_err_o  (fe_a),
    .parity_err_o (pe_a),
    .overrun_o    (ov_a),
    .clr_err_i    (clr_a)
  );

  uart_rx_capture #(
    .CLK_DIV     (C_B),
    .PARITY_MODE (PARITY_EVEN),
    .FIFO_DEPTH  (4)
  ) dut_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_i         (rx_b),
    .rx_en_i      (en_b),
    .rdata_o      (rd_b.rdata),
    .rvalid_o     (rd_b.rvalid),
    .rready_i     (rd_b.rready),
    .count_o      (rd_b.count),
    .frame_err_o  (fe_b),
    .parity_err_o (pe_b),
    .overrun_o    (ov_b),
    .clr_err_i    (clr_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (dut_a.state_q == BREAK) break_seen <= break_seen + 1;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && rd_a.rvalid && rd_a.rready) begin
      if (q_a.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL pop_a: got unexpected data 0x%0h, expected no frame", rd_a.rdata);
      end else begin
        e = q_a.pop_front();
        check("rdata_a", 32'(rd_a.rdata), 32'(e.data));
        check("rise_cycle_a", cyc, e.rise);
      end
    end
  end

  always @(negedge clk) begin
    logic [7:0] d;
    if (rst_n && rd_b.rvalid && rd_b.rready) begin
      if (q_b.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL pop_b: got unexpected data 0x%0h, expected no frame", rd_b.rdata);
      end else begin
        d = q_b.pop_front();
        check("rdata_b", 32'(rd_b.rdata), 32'(d));
      end
    end
  end

  task automatic drive(input bit on_b, input logic v, input int n);
    if (on_b) rx_b = v;
    else      rx_a = v;
    repeat (n) @(negedge clk);
  endtask

  // Called on a negedge; the start bit begins at that negedge.
  task automatic send_frame(input bit on_b, input logic [7:0] data, input logic par,
                            input int stop_low, input bit expect_it);
    int   c;
    exp_t e;
    c = on_b ? C_B : C_A;
    if (expect_it) begin
      if (on_b) begin
        q_b.push_back(data);
      end else begin
        e.data = data;
        e.rise = cyc + RISE_A;
        q_a.push_back(e);
      end
    end
    drive(on_b, 1'b0, c);
    for (int i = 0; i < 8; i++) drive(on_b, data[i], c);
    if (on_b) drive(on_b, par, c);
    if (stop_low > 0) drive(on_b, 1'b0, c * stop_low);
    drive(on_b, 1'b1, 2 * c);
  endtask

  task automatic drain_b();
    @(posedge clk);
    #1 rd_b.rready = 1'b1;
    for (int i = 0; i < 20 && q_b.size() != 0; i++) @(negedge clk);
    @(posedge clk);
    #1 rd_b.rready = 1'b0;
    @(negedge clk);
    check("drain_b_count", 32'(rd_b.count), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] frames [5];
    int b0;
    frames = '{8'h01, 8'h22, 8'h37, 8'h44, 8'h58};
    rd_a.rready = 1'b1;
    rd_b.rready = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_rvalid_a", 32'(rd_a.rvalid), 0);
    check("reset_count_a", 32'(rd_a.count), 0);
    check("reset_rdata_a", 32'(rd_a.rdata), 0);
    check("reset_flags_a", 32'({fe_a, pe_a, ov_a}), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Basic frame with latency check in the monitor.
    send_frame(1'b0, 8'hA5, 1'b0, 0, 1'b1);
    check("a5_flags", 32'({fe_a, pe_a, ov_a}), 0);

    // Short glitch shorter than half a bit.
    rx_a = 1'b0;
    repeat (C_A / 4) @(negedge clk);
    rx_a = 1'b1;
    repeat (2 * C_A) @(negedge clk);
    check("glitch_count", 32'(rd_a.count), 0);
    check("glitch_flags", 32'({fe_a, pe_a, ov_a}), 0);
    check("glitch_state_idle", 32'(dut_a.state_q), 32'(IDLE));

    // Enable dropped mid-frame: current frame completes, the next is ignored.
    fork
      send_frame(1'b0, 8'h81, 1'b0, 0, 1'b1);
      begin
        repeat (3 * C_A) @(negedge clk);
        en_a = 1'b0;
      end
    join
    send_frame(1'b0, 8'h42, 1'b0, 0, 1'b0);
    check("disabled_count", 32'(rd_a.count), 0);
    en_a = 1'b1;

    // Stop bit held low for three bit times.
    b0 = break_seen;
    send_frame(1'b0, 8'hF0, 1'b0, 3, 1'b0);
    check("frame_err_set", 32'(fe_a), 1);
    check("break_visited", 32'(break_seen > b0), 1);
    send_frame(1'b0, 8'h3C, 1'b0, 0, 1'b1);
    check("frame_err_sticky", 32'(fe_a), 1);
    check("after_break_other_flags", 32'({pe_a, ov_a}), 0);

    // Even parity: 0x07 needs parity bit 1.
    send_frame(1'b1, 8'h07, 1'b0, 0, 1'b0);
    check("parity_err_set", 32'(pe_b), 1);
    check("parity_bad_count", 32'(rd_b.count), 0);
    check("parity_bad_rvalid", 32'(rd_b.rvalid), 0);
    clr_b = 1'b1;
    @(negedge clk);
    clr_b = 1'b0;
    check("parity_err_cleared", 32'(pe_b), 0);
    send_frame(1'b1, 8'h07, 1'b1, 0, 1'b1);
    check("parity_good_count", 32'(rd_b.count), 1);
    check("parity_good_head", 32'(rd_b.rdata), 32'h07);
    check("parity_good_flag", 32'(pe_b), 0);
    drain_b();

    // Fill the 4-entry FIFO and overflow it.
    for (int i = 0; i < 5; i++) send_frame(1'b1, frames[i], ^frames[i], 0, i < 4);
    check("full_count", 32'(rd_b.count), 4);
    check("overrun_set", 32'(ov_b), 1);
    check("full_head", 32'(rd_b.rdata), 32'h01);
    check("full_rvalid", 32'(rd_b.rvalid), 1);

    // Another dropped frame with clr_err in the push cycle: the error wins.
    fork
      send_frame(1'b1, 8'h6B, 1'b1, 0, 1'b0);
      begin
        repeat (PUSH_B) @(negedge clk);
        clr_b = 1'b1;
        @(negedge clk);
        clr_b = 1'b0;
      end
    join
    check("overrun_beats_clear", 32'(ov_b), 1);
    check("overrun_count_kept", 32'(rd_b.count), 4);
    clr_b = 1'b1;
    @(negedge clk);
    clr_b = 1'b0;
    check("overrun_cleared", 32'(ov_b), 0);

    // Full FIFO with push and pop in the same cycle.
    fork
      send_frame(1'b1, 8'h7E, 1'b0, 0, 1'b1);
      begin
        repeat (PUSH_B - 1) @(negedge clk);
        @(posedge clk);
        #1 rd_b.rready = 1'b1;
        @(posedge clk);
        #1 rd_b.rready = 1'b0;
      end
    join
    check("push_pop_count", 32'(rd_b.count), 4);
    check("push_pop_no_overrun", 32'(ov_b), 0);
    check("push_pop_head", 32'(rd_b.rdata), 32'h22);
    drain_b();

    // Reset in the middle of the data bits.
    drive(1'b0, 1'b0, C_A);
    drive(1'b0, 1'b1, C_A);
    drive(1'b0, 1'b0, C_A / 2);
    check("state_data_before_reset", 32'(dut_a.state_q), 32'(DATA));
    #2 rst_n = 1'b0;
    #1;
    check("rst_rvalid_a", 32'(rd_a.rvalid), 0);
    check("rst_count_a", 32'(rd_a.count), 0);
    check("rst_rdata_a", 32'(rd_a.rdata), 0);
    check("rst_flags_a", 32'({fe_a, pe_a, ov_a}), 0);
    check("rst_state_idle", 32'(dut_a.state_q), 32'(IDLE));
    rx_a = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * C_A) @(negedge clk);
    check("post_rst_count", 32'(rd_a.count), 0);
    send_frame(1'b0, 8'h5A, 1'b0, 0, 1'b1);
    check("post_rst_flags", 32'({fe_a, pe_a, ov_a}), 0);

    for (int i = 0; i < 400 && (q_a.size() + q_b.size()) != 0; i++) @(negedge clk);
    check("scoreboard_empty", q_a.size() + q_b.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
